// File: rtl/writeback_arbiter.sv
// Writeback arbiter: per-source result FIFOs feeding the two register-file write
// ports through a round-robin dual grant that never issues two writes to one register.

module writeback_arbiter #(
    parameter int N_SRC      = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_src_valid [0:N_SRC-1],
    output logic        o_src_ready [0:N_SRC-1],
    input  logic [6:0]  i_src_addr  [0:N_SRC-1],
    input  logic [31:0] i_src_data  [0:N_SRC-1],
    output logic        o_w_en      [0:1],
    output logic [6:0]  o_w_addr    [0:1],
    output logic [31:0] o_w_data    [0:1],
    output logic        o_idle
);

    localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [SW-1:0] SRC_LAST = SW'(N_SRC - 1);

    logic [6:0]    r_mem_addr [N_SRC][FIFO_DEPTH];
    logic [31:0]   r_mem_data [N_SRC][FIFO_DEPTH];
    logic [PW-1:0] r_wptr     [N_SRC];
    logic [PW-1:0] r_rptr     [N_SRC];
    logic [CW-1:0] r_count    [N_SRC];
    logic [SW-1:0] r_rr;
    logic          r_w_en     [0:1];
    logic [6:0]    r_w_addr   [0:1];
    logic [31:0]   r_w_data   [0:1];

    logic          w_nonempty  [N_SRC];
    logic          w_ready     [N_SRC];
    logic          w_enq       [N_SRC];
    logic          w_pop       [N_SRC];
    logic [6:0]    w_head_addr [N_SRC];
    logic [31:0]   w_head_data [N_SRC];
    logic          w_g0_vld;
    logic          w_g1_vld;
    logic [SW-1:0] w_g0_src;
    logic [SW-1:0] w_g1_src;
    logic [6:0]    w_g0_addr;
    logic [6:0]    w_g1_addr;
    logic [31:0]   w_g0_data;
    logic [31:0]   w_g1_data;
    logic [SW-1:0] w_last;
    logic [SW-1:0] w_rr_next;
    logic          w_all_empty;

    // Per-source status; ready ignores a same-cycle pop, and p0 writes are accepted then dropped.
    always_comb begin
        for (int s = 0; s < N_SRC; s++) begin
            w_nonempty[s]  = (r_count[s] != {CW{1'b0}});
            w_ready[s]     = i_rst_n && (r_count[s] < DEPTH_C);
            w_enq[s]       = i_src_valid[s] && w_ready[s] && (i_src_addr[s] != 7'd0);
            w_head_addr[s] = r_mem_addr[s][r_rptr[s]];
            w_head_data[s] = r_mem_data[s][r_rptr[s]];
        end
    end

    // Round-robin scan from r_rr: first head takes port 0, next head with a different address takes port 1.
    always_comb begin : arb
        logic [SW-1:0] v_scan;
        logic          v_take0;
        logic          v_take1;
        v_scan    = r_rr;
        v_take0   = 1'b0;
        v_take1   = 1'b0;
        w_g0_vld  = 1'b0;
        w_g1_vld  = 1'b0;
        w_g0_src  = {SW{1'b0}};
        w_g1_src  = {SW{1'b0}};
        w_g0_addr = 7'd0;
        w_g1_addr = 7'd0;
        w_g0_data = 32'd0;
        w_g1_data = 32'd0;
        for (int k = 0; k < N_SRC; k++) begin
            v_take0 = w_nonempty[v_scan] && !w_g0_vld;
            v_take1 = w_nonempty[v_scan] && w_g0_vld && !w_g1_vld &&
                      (w_head_addr[v_scan] != w_g0_addr);
            if (v_take0) begin
                w_g0_vld  = 1'b1;
                w_g0_src  = v_scan;
                w_g0_addr = w_head_addr[v_scan];
                w_g0_data = w_head_data[v_scan];
            end else if (v_take1) begin
                w_g1_vld  = 1'b1;
                w_g1_src  = v_scan;
                w_g1_addr = w_head_addr[v_scan];
                w_g1_data = w_head_data[v_scan];
            end else begin
                v_take1 = 1'b0;
            end
            if (v_scan == SRC_LAST) begin
                v_scan = {SW{1'b0}};
            end else begin
                v_scan = v_scan + SW'(1);
            end
        end
    end

    // Pop strobes, next round-robin pointer and the all-empty flag.
    always_comb begin
        w_all_empty = 1'b1;
        for (int s = 0; s < N_SRC; s++) begin
            w_pop[s] = (w_g0_vld && (w_g0_src == SW'(s))) ||
                       (w_g1_vld && (w_g1_src == SW'(s)));
            w_all_empty = w_all_empty && !w_nonempty[s];
        end
        if (w_g1_vld) begin
            w_last = w_g1_src;
        end else begin
            w_last = w_g0_src;
        end
        if (w_last == SRC_LAST) begin
            w_rr_next = {SW{1'b0}};
        end else begin
            w_rr_next = w_last + SW'(1);
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int s = 0; s < N_SRC; s++) begin
                r_wptr[s]  <= {PW{1'b0}};
                r_rptr[s]  <= {PW{1'b0}};
                r_count[s] <= {CW{1'b0}};
            end
        end else begin
            for (int s = 0; s < N_SRC; s++) begin
                if (w_enq[s]) begin
                    r_wptr[s] <= (r_wptr[s] == PTR_LAST) ? {PW{1'b0}} : r_wptr[s] + PW'(1);
                end
                if (w_pop[s]) begin
                    r_rptr[s] <= (r_rptr[s] == PTR_LAST) ? {PW{1'b0}} : r_rptr[s] + PW'(1);
                end
                case ({w_enq[s], w_pop[s]})
                    2'b10:   r_count[s] <= r_count[s] + CW'(1);
                    2'b01:   r_count[s] <= r_count[s] - CW'(1);
                    default: r_count[s] <= r_count[s];
                endcase
            end
        end
    end

    // FIFO storage; enqueue is already gated off while reset is asserted.
    always_ff @(posedge i_clk) begin
        for (int s = 0; s < N_SRC; s++) begin
            if (w_enq[s]) begin
                r_mem_addr[s][r_wptr[s]] <= i_src_addr[s];
                r_mem_data[s][r_wptr[s]] <= i_src_data[s];
            end
        end
    end

    // Registered write ports and round-robin pointer; an ungranted port drives all zeros.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rr <= {SW{1'b0}};
            for (int p = 0; p < 2; p++) begin
                r_w_en[p]   <= 1'b0;
                r_w_addr[p] <= 7'd0;
                r_w_data[p] <= 32'd0;
            end
        end else begin
            r_w_en[0]   <= w_g0_vld;
            r_w_addr[0] <= w_g0_addr;
            r_w_data[0] <= w_g0_data;
            r_w_en[1]   <= w_g1_vld;
            r_w_addr[1] <= w_g1_addr;
            r_w_data[1] <= w_g1_data;
            if (w_g0_vld) begin
                r_rr <= w_rr_next;
            end
        end
    end

    assign o_src_ready = w_ready;
    assign o_w_en      = r_w_en;
    assign o_w_addr    = r_w_addr;
    assign o_w_data    = r_w_data;
    assign o_idle      = w_all_empty && !r_w_en[0] && !r_w_en[1];

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed cycle table, saturation and mid-stream reset
// sequences, then random traffic checked against a queue-level reference model.

module tb_writeback_arbiter;

    localparam int NS    = 3;
    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        in_valid  [0:NS-1];
    logic        src_ready [0:NS-1];
    logic [6:0]  in_addr   [0:NS-1];
    logic [31:0] in_data   [0:NS-1];
    logic        w_en      [0:1];
    logic [6:0]  w_addr    [0:1];
    logic [31:0] w_data    [0:1];
    logic        idle;

    int n_chk  = 0;
    int n_fail = 0;

    writeback_arbiter dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_src_valid (in_valid),
        .o_src_ready (src_ready),
        .i_src_addr  (in_addr),
        .i_src_data  (in_data),
        .o_w_en      (w_en),
        .o_w_addr    (w_addr),
        .o_w_data    (w_data),
        .o_idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each FIFO is an ordered list, head at index 0.
    int          m_size [NS];
    logic [6:0]  m_addr [NS][DEPTH];
    logic [31:0] m_data [NS][DEPTH];
    int          m_rr;
    logic        e_en   [2];
    logic [6:0]  e_addr [2];
    logic [31:0] e_data [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic bit exp_ready(input int s);
        return rst_n && (m_size[s] < DEPTH);
    endfunction

    function automatic bit exp_idle();
        return (m_size[0] == 0) && (m_size[1] == 0) && (m_size[2] == 0) && !e_en[0] && !e_en[1];
    endfunction

    task automatic model_pop(input int s);
        for (int j = 0; j < DEPTH - 1; j++) begin
            m_addr[s][j] = m_addr[s][j+1];
            m_data[s][j] = m_data[s][j+1];
        end
        m_size[s]--;
    endtask

    // Applies one rising edge to the model using the inputs currently driven.
    task automatic model_edge();
        int  g0;
        int  g1;
        int  s;
        bit  rdy [NS];
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) m_size[i] = 0;
            m_rr = 0;
            for (int p = 0; p < 2; p++) begin
                e_en[p] = 1'b0; e_addr[p] = 7'd0; e_data[p] = 32'd0;
            end
        end else begin
            for (int i = 0; i < NS; i++) rdy[i] = (m_size[i] < DEPTH);
            g0 = -1;
            g1 = -1;
            for (int k = 0; k < NS; k++) begin
                s = (m_rr + k) % NS;
                if (m_size[s] > 0) begin
                    if (g0 < 0) g0 = s;
                    else if (g1 < 0 && m_addr[s][0] != m_addr[g0][0]) g1 = s;
                end
            end
            for (int p = 0; p < 2; p++) begin
                e_en[p] = 1'b0; e_addr[p] = 7'd0; e_data[p] = 32'd0;
            end
            if (g0 >= 0) begin
                e_en[0] = 1'b1; e_addr[0] = m_addr[g0][0]; e_data[0] = m_data[g0][0];
            end
            if (g1 >= 0) begin
                e_en[1] = 1'b1; e_addr[1] = m_addr[g1][0]; e_data[1] = m_data[g1][0];
            end
            if (g0 >= 0) model_pop(g0);
            if (g1 >= 0) model_pop(g1);
            if (g0 >= 0) m_rr = (((g1 >= 0) ? g1 : g0) + 1) % NS;
            for (int i = 0; i < NS; i++) begin
                if (in_valid[i] && rdy[i] && in_addr[i] != 7'd0) begin
                    m_addr[i][m_size[i]] = in_addr[i];
                    m_data[i][m_size[i]] = in_data[i];
                    m_size[i]++;
                end
            end
        end
    endtask

    task automatic compare_model(input string tag);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("%s w_en[%0d]", tag, p), 32'(w_en[p]), 32'(e_en[p]));
            chk($sformatf("%s w_addr[%0d]", tag, p), 32'(w_addr[p]), 32'(e_addr[p]));
            chk($sformatf("%s w_data[%0d]", tag, p), w_data[p], e_data[p]);
        end
        for (int s = 0; s < NS; s++)
            chk($sformatf("%s ready[%0d]", tag, s), 32'(src_ready[s]), 32'(exp_ready(s)));
        chk($sformatf("%s idle", tag), 32'(idle), 32'(exp_idle()));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    typedef struct packed {
        logic        rst_n;
        logic [2:0]  v;
        logic [20:0] a;
        logic [95:0] d;
        logic [1:0]  en;
        logic [13:0] wa;
        logic [63:0] wd;
        logic [2:0]  rdy;
        logic        idle;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [2:0] v,
                                input logic [6:0] a0, input logic [6:0] a1, input logic [6:0] a2,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [1:0] en, input logic [6:0] wa0, input logic [31:0] wd0,
                                input logic [6:0] wa1, input logic [31:0] wd1,
                                input logic [2:0] rdy, input logic id);
        vec_t t;
        t.rst_n = r;  t.v = v;  t.a = {a2, a1, a0};  t.d = {d2, d1, d0};
        t.en = en;  t.wa = {wa1, wa0};  t.wd = {wd1, wd0};  t.rdy = rdy;  t.idle = id;
        return t;
    endfunction

    function automatic vec_t mkn(input logic [1:0] en, input logic [6:0] wa0, input logic [31:0] wd0,
                                 input logic [6:0] wa1, input logic [31:0] wd1, input logic id);
        return mk(1'b1, 3'b000, 7'd0, 7'd0, 7'd0, 32'd0, 32'd0, 32'd0,
                  en, wa0, wd0, wa1, wd1, 3'b111, id);
    endfunction

    localparam int NV = 19;
    vec_t vecs [NV];

    logic [31:0] sat_d    [NS];
    logic [31:0] exp_next [NS];
    int          grants   [NS];
    bit          acc      [NS];
    bit          pend     [NS];
    bit          saw_full;
    int          src;
    int          gmax;
    int          gmin;

    initial begin
        // Directed cycles: inputs applied in the row's cycle, outputs expected in that same cycle.
        vecs[0]  = mk(1'b0, 3'b000, 7'd0, 7'd0, 7'd0, 32'd0, 32'd0, 32'd0,
                      2'b00, 7'd0, 32'd0, 7'd0, 32'd0, 3'b000, 1'b1);
        vecs[1]  = mkn(2'b00, 7'd0, 32'd0, 7'd0, 32'd0, 1'b1);
        vecs[2]  = mk(1'b1, 3'b111, 7'd10, 7'd11, 7'd12, 32'hA0, 32'hA1, 32'hA2,
                      2'b00, 7'd0, 32'd0, 7'd0, 32'd0, 3'b111, 1'b1);
        vecs[3]  = mkn(2'b00, 7'd0, 32'd0, 7'd0, 32'd0, 1'b0);
        vecs[4]  = mkn(2'b11, 7'd10, 32'hA0, 7'd11, 32'hA1, 1'b0);
        vecs[5]  = mkn(2'b01, 7'd12, 32'hA2, 7'd0, 32'd0, 1'b0);
        vecs[6]  = mkn(2'b00, 7'd0, 32'd0, 7'd0, 32'd0, 1'b1);
        vecs[7]  = mk(1'b1, 3'b011, 7'd9, 7'd9, 7'd0, 32'd1, 32'd2, 32'd0,
                      2'b00, 7'd0, 32'd0, 7'd0, 32'd0, 3'b111, 1'b1);
        vecs[8]  = mkn(2'b00, 7'd0, 32'd0, 7'd0, 32'd0, 1'b0);
        vecs[9]  = mkn(2'b01, 7'd9, 32'd1, 7'd0, 32'd0, 1'b0);
        vecs[10] = mkn(2'b01, 7'd9, 32'd2, 7'd0, 32'd0, 1'b0);
        vecs[11] = mkn(2'b00, 7'd0, 32'd0, 7'd0, 32'd0, 1'b1);
        vecs[12] = mk(1'b1, 3'b010, 7'd0, 7'd5, 7'd0, 32'd0, 32'hDEADBEEF, 32'd0,
                      2'b00, 7'd0, 32'd0, 7'd0, 32'd0, 3'b111, 1'b1);
        vecs[13] = mkn(2'b00, 7'd0, 32'd0, 7'd0, 32'd0, 1'b0);
        vecs[14] = mkn(2'b01, 7'd5, 32'hDEADBEEF, 7'd0, 32'd0, 1'b0);
        vecs[15] = mkn(2'b00, 7'd0, 32'd0, 7'd0, 32'd0, 1'b1);
        vecs[16] = mk(1'b1, 3'b100, 7'd0, 7'd0, 7'd0, 32'd0, 32'd0, 32'h1234,
                      2'b00, 7'd0, 32'd0, 7'd0, 32'd0, 3'b111, 1'b1);
        vecs[17] = mkn(2'b00, 7'd0, 32'd0, 7'd0, 32'd0, 1'b1);
        vecs[18] = mkn(2'b00, 7'd0, 32'd0, 7'd0, 32'd0, 1'b1);

        rst_n = 1'b0;
        m_rr  = 0;
        for (int s = 0; s < NS; s++) begin
            in_valid[s] = 1'b0; in_addr[s] = 7'd0; in_data[s] = 32'd0;
            m_size[s] = 0; pend[s] = 1'b0; grants[s] = 0;
        end
        for (int p = 0; p < 2; p++) begin
            e_en[p] = 1'b0; e_addr[p] = 7'd0; e_data[p] = 32'd0;
        end
        repeat (2) begin
            @(posedge clk);
            model_edge();
        end
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            rst_n = vecs[i].rst_n;
            for (int s = 0; s < NS; s++) begin
                in_valid[s] = vecs[i].v[s];
                in_addr[s]  = vecs[i].a[s*7 +: 7];
                in_data[s]  = vecs[i].d[s*32 +: 32];
            end
            #1;
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("vec%0d w_en[%0d]", i, p), 32'(w_en[p]), 32'(vecs[i].en[p]));
                chk($sformatf("vec%0d w_addr[%0d]", i, p), 32'(w_addr[p]), 32'(vecs[i].wa[p*7 +: 7]));
                chk($sformatf("vec%0d w_data[%0d]", i, p), w_data[p], vecs[i].wd[p*32 +: 32]);
            end
            chk($sformatf("vec%0d ready", i), 32'({src_ready[2], src_ready[1], src_ready[0]}),
                32'(vecs[i].rdy));
            chk($sformatf("vec%0d idle", i), 32'(idle), 32'(vecs[i].idle));
            tick();
        end

        // Saturation: every source always valid, data advancing only on acceptance.
        saw_full = 1'b0;
        for (int s = 0; s < NS; s++) begin
            sat_d[s]    = 32'(s) << 16;
            exp_next[s] = 32'(s) << 16;
        end
        for (int c = 1; c <= 20; c++) begin
            rst_n = 1'b1;
            for (int s = 0; s < NS; s++) begin
                in_valid[s] = 1'b1;
                in_addr[s]  = 7'(40 + s);
                in_data[s]  = sat_d[s];
            end
            #1;
            compare_model($sformatf("sat%0d", c));
            for (int s = 0; s < NS; s++) if (!src_ready[s]) saw_full = 1'b1;
            if (c >= 3) chk($sformatf("sat%0d two_writes", c), 32'({w_en[0], w_en[1]}), 32'd3);
            for (int p = 0; p < 2; p++) begin
                if (w_en[p]) begin
                    src = int'(w_addr[p]) - 40;
                    chk($sformatf("sat%0d addr_range[%0d]", c, p), 32'(src >= 0 && src < NS), 32'd1);
                    if (src >= 0 && src < NS) begin
                        chk($sformatf("sat%0d order src%0d", c, src), w_data[p], exp_next[src]);
                        exp_next[src] = exp_next[src] + 32'd1;
                        grants[src]++;
                    end
                end
            end
            for (int s = 0; s < NS; s++) acc[s] = exp_ready(s);
            tick();
            for (int s = 0; s < NS; s++) if (acc[s]) sat_d[s] = sat_d[s] + 32'd1;
        end
        chk("sat ready_dropped", 32'(saw_full), 32'd1);
        gmax = grants[0];
        gmin = grants[0];
        for (int s = 1; s < NS; s++) begin
            if (grants[s] > gmax) gmax = grants[s];
            if (grants[s] < gmin) gmin = grants[s];
        end
        chk("sat fairness", 32'(gmax - gmin <= 1), 32'd1);

        // Reset while FIFOs are occupied and both ports are writing.
        rst_n = 1'b0;
        #1;
        compare_model("rst_edge");
        tick();
        rst_n = 1'b1;
        for (int s = 0; s < NS; s++) in_valid[s] = 1'b0;
        #1;
        chk("rst_after w_en0", 32'(w_en[0]), 32'd0);
        chk("rst_after w_en1", 32'(w_en[1]), 32'd0);
        chk("rst_after idle", 32'(idle), 32'd1);
        for (int c = 0; c < 6; c++) begin
            tick();
            #1;
            chk($sformatf("rst_quiet%0d en", c), 32'({w_en[0], w_en[1]}), 32'd0);
            compare_model($sformatf("rst_quiet%0d", c));
        end

        // Random traffic with collisions, p0 writes, held requests and occasional resets.
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            for (int s = 0; s < NS; s++) begin
                if (!pend[s] && $urandom_range(0, 3) != 0) begin
                    pend[s]    = 1'b1;
                    in_addr[s] = 7'($urandom_range(0, 7));
                    in_data[s] = $urandom;
                end
                in_valid[s] = pend[s];
            end
            #1;
            compare_model($sformatf("rnd%0d", c));
            for (int s = 0; s < NS; s++) acc[s] = pend[s] && exp_ready(s);
            tick();
            for (int s = 0; s < NS; s++) if (acc[s]) pend[s] = 1'b0;
        end
        rst_n = 1'b1;
        for (int s = 0; s < NS; s++) in_valid[s] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            compare_model($sformatf("drain%0d", c));
            tick();
        end
        #1;
        chk("drain final idle", 32'(idle), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
